// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial bit-stream blocks
// (the parallel-in serial-out serializer and the serial-to-parallel collector).
//   state_t    - two-state FSM encoding (IDLE, SHIFT)
//   SER_WIDTH  - default operand width in bits
package serial_pkg;

  localparam int SER_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake and serial output bundle for the serializer.
//   din        - parallel word to serialize (WIDTH bits)
//   load_valid - din is valid and held until accepted
//   load_ready - serializer can accept din this cycle
//   shift      - advance one bit at the next edge; low stalls the stream
//   sout       - current serial bit, LSB first
//   sout_valid - sout carries a valid bit
//   sout_last  - sout is the final bit of the current word
//   busy       - a word is in flight
// master: the block that loads words and drives shift; slave: the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = serial_pkg::SER_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             shift;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output din, load_valid, shift,
    input  load_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  din, load_valid, shift,
    output load_ready, sout, sout_valid, sout_last, busy
  );

endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: accepts a WIDTH-bit word over a valid/ready handshake and
// emits it LSB-first, one bit per cycle in which shift is high. A new word can
// be accepted on the edge that consumes the final bit of the current one, so
// back-to-back words stream without a bubble.
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; aborts any word in flight
//   bus   - piso_serializer_if slave modport (handshake + serial outputs)
// Parameters: WIDTH >= 2; CNT_W with 2**CNT_W > WIDTH-1.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int CNT_W = 3
) (
  input logic               clk,
  input logic               reset,
  piso_serializer_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt,   cnt_nxt;

  logic at_last;
  logic load_ready;
  logic accept;

  assign at_last = (state == SHIFT) && (cnt == LAST_CNT);

  // The only input-to-output path: a reload is possible on the final bit
  // only if that bit is actually consumed at this edge.
  assign load_ready = !reset && ((state == IDLE) || (at_last && bus.shift));
  assign accept     = bus.load_valid && load_ready;

  assign bus.load_ready = load_ready;

  // NOTE: every register, the shift register included, is cleared by the
  // async reset so no stale bits can leak out after an abort.
  // NOTE: state updates use non-blocking assignments so all registers see
  // pre-edge values of each other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first, so no path through the case
    // leaves a variable unassigned (which would infer a latch).
    state_nxt      = state;
    shreg_nxt      = shreg;
    cnt_nxt        = cnt;
    bus.sout       = 1'b0;
    bus.sout_valid = 1'b0;
    bus.sout_last  = 1'b0;
    bus.busy       = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          shreg_nxt = bus.din;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        // Outputs come straight from registers; reset clears state at once,
        // so they drop without waiting for a clock edge.
        bus.sout       = shreg[0];
        bus.sout_valid = 1'b1;
        bus.sout_last  = at_last;
        bus.busy       = 1'b1;

        if (bus.shift) begin
          if (!at_last) begin
            shreg_nxt = shreg >> 1;
            cnt_nxt   = cnt + 1'b1;
          end else if (accept) begin
            shreg_nxt = bus.din;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out shifter that feeds one operand word LSB-first into the serial adder datapath. It is the transmit end of the serial bit stream whose receive end is the serial-to-parallel collector. It accepts a WIDTH-bit word over a valid/ready handshake and emits one bit per enabled cycle, with valid and last-bit markers. Back-to-back words stream without bubbles.

Parameters:
WIDTH, 4, operand width in bits; must be at least 2.
CNT_W, 3, bit-counter width; must satisfy 2**CNT_W > WIDTH-1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
din  input  WIDTH  parallel word to serialize
load_valid  input  1  din is valid; source holds din stable until accepted
load_ready  output  1  serializer can accept din this cycle
shift  input  1  advance one bit at this edge; low stalls the stream
sout  output  1  current serial bit, LSB-first
sout_valid  output  1  sout carries a valid bit
sout_last  output  1  sout is bit WIDTH-1 of the current word
busy  output  1  a word is in flight (state SHIFT)

Behaviour:
- Registers: state {IDLE, SHIFT}, shreg[WIDTH-1:0], cnt[CNT_W-1:0].
- Reset asserted, asynchronously: state=IDLE, shreg=0, cnt=0.
- While reset is asserted: sout=0, sout_valid=0, sout_last=0, busy=0, load_ready=0.
- The abort takes effect immediately, mid-word included. No partial bits are emitted after reset is released.
- Accept condition: load_valid && load_ready at a rising edge.
- load_ready = !reset && (state==IDLE || (state==SHIFT && cnt==WIDTH-1 && shift)).
- IDLE:
  - sout=0, sout_valid=0, sout_last=0, busy=0.
  - On accept: shreg<=din, cnt<=0, state<=SHIFT.
- SHIFT:
  - sout=shreg[0], sout_valid=1, busy=1, sout_last=(cnt==WIDTH-1). All are decoded from registers; no combinational path from inputs except load_ready.
  - shift=0: hold shreg, cnt and all outputs (stall).
  - shift=1 and cnt<WIDTH-1: shreg<=shreg>>1 (zero fill at MSB), cnt<=cnt+1.
  - shift=1 and cnt==WIDTH-1, with accept: shreg<=din, cnt<=0, stay in SHIFT. This is back-to-back with no idle cycle.
  - shift=1 and cnt==WIDTH-1, without accept: state<=IDLE, cnt<=0.
- load_valid in SHIFT before the final bit is ignored (load_ready=0). din is not sampled.
- Latency: accept at edge N -> bit0 on sout during cycle after edge N. With shift held high, a word occupies exactly WIDTH cycles.
- cnt never exceeds WIDTH-1. No wrap beyond that value; it resets to 0 on reload or return to IDLE.
- shift while in IDLE has no effect.

Decomposition:
- Shared package serial_pkg: state typedef (IDLE, SHIFT) and the default operand width constant SER_WIDTH=4. The serial-to-parallel collector uses the same package.
- No sub-module. Counter and shifter stay inline; the block is a single FSM plus datapath.

Test Plan:
- Reset release; din=4'b1011 with a 1-cycle load_valid pulse; shift=1 -> sout=1,1,0,1 on 4 consecutive cycles; sout_last only on the 4th; then sout_valid=0, load_ready=1.
- Back-to-back: din=4'hA then 4'h5, load_valid held, shift=1 -> 8 contiguous valid bits 0,1,0,1,1,0,1,0; load_ready pulses only on the last bit of word 1; sout_last on bits 4 and 8.
- Stall: din=4'b0110, shift low for 2 cycles after bit1 -> sout holds 1 and sout_valid stays 1 during the stall; full sequence 0,1,1,0; cnt does not advance.
- Ignored load: load 4'hF; assert load_valid with din=4'h0 from bit1 onward -> stream 1,1,1,1 unchanged; 4'h0 accepted only at the last-bit edge, then 0,0,0,0.
- Async reset mid-word: load 4'h9, assert reset between edges after bit1 -> sout, sout_valid, sout_last, busy and load_ready drop to 0 without a clock edge. After release, load_ready=1 and a new load of 4'h3 emits 1,1,0,0.
- WIDTH=8, CNT_W=3: din=8'h81 -> 1,0,0,0,0,0,0,1, with sout_last on the 8th bit.
